// File: rtl/cnn_conv_pkg.sv
// Shared conv-stage constants and the image buffer state encoding.
// Imported by the patch fetcher, the conv controller and the image buffer.
package cnn_conv_pkg;

  localparam int IMG_W      = 28;
  localparam int IMG_H      = 28;
  localparam int PIXEL_W    = 8;
  localparam int ADDR_W     = 10;
  localparam int IMG_PIXELS = IMG_W * IMG_H;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_FULL    = 2'd2
  } buf_state_t;

endpackage

// File: rtl/dual_read_ram.sv
// Image store: one write port and two registered read ports, read-before-write.
// With ZERO_PAD_EN, an out-of-image read returns 0; otherwise that port holds its last value.
module dual_read_ram #(
  parameter int N  = 784,
  parameter int W  = 8,
  parameter int AW = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic signed [W-1:0] wdata,
  input  logic [AW-1:0]       addr1,
  input  logic [AW-1:0]       addr2,
  output logic signed [W-1:0] data1,
  output logic signed [W-1:0] data2
);

  localparam logic [AW-1:0] N_A = AW'(N);

  logic signed [W-1:0] mem [N];

  // No reset on the array so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data1 <= '0;
      data2 <= '0;
    end else begin
      if (addr1 < N_A) data1 <= mem[addr1];
`ifdef ZERO_PAD_EN
      else             data1 <= '0;
`endif
      if (addr2 < N_A) data2 <= mem[addr2];
`ifdef ZERO_PAD_EN
      else             data2 <= '0;
`endif
    end
  end

endmodule

// File: rtl/patch_image_buffer.sv
// Input image buffer: fill FSM, write counter, frame handshake and error flag.
// Out-of-image read behaviour is selected by ZERO_PAD_EN (see dual_read_ram).
//
// state      | meaning
// ST_EMPTY   | no image, waiting for the first pixel
// ST_LOADING | pixels arriving, image incomplete
// ST_FULL    | image resident, writes blocked until frame_consumed
module patch_image_buffer
  import cnn_conv_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic signed [PIXEL_W-1:0] wr_data,
  input  logic                      wr_last,
  input  logic                      frame_start,
  output logic                      frame_ready,
  input  logic                      frame_consumed,
  output logic                      frame_err,
  input  logic [ADDR_W-1:0]         addr1,
  input  logic [ADDR_W-1:0]         addr2,
  output logic signed [PIXEL_W-1:0] data1,
  output logic signed [PIXEL_W-1:0] data2
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMG_PIXELS - 1);

  buf_state_t        state, state_nxt;
  logic [ADDR_W-1:0] wr_cnt;
  logic              accept;
  logic              at_last;

  assign wr_ready    = (state != ST_FULL);
  assign frame_ready = (state == ST_FULL);
  assign accept      = wr_valid & wr_ready;
  assign at_last     = (wr_cnt == LAST_IDX);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY, ST_LOADING: begin
        if (accept) state_nxt = (wr_last || at_last) ? ST_FULL : ST_LOADING;
      end
      ST_FULL: begin
        if (frame_consumed) state_nxt = ST_EMPTY;
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (frame_start) state_nxt = ST_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      wr_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      state <= state_nxt;
      // Counter rewinds when the image is released so the next frame starts at 0.
      if (frame_start || (state == ST_FULL && frame_consumed))
        wr_cnt <= '0;
      else if (accept && !at_last)
        wr_cnt <= wr_cnt + 1'b1;
      if (frame_start)
        frame_err <= 1'b0;
      else if (accept && (wr_last != at_last))
        frame_err <= 1'b1;
    end
  end

  dual_read_ram #(
    .N  (IMG_PIXELS),
    .W  (PIXEL_W),
    .AW (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .waddr (wr_cnt),
    .wdata (wr_data),
    .addr1 (addr1),
    .addr2 (addr2),
    .data1 (data1),
    .data2 (data2)
  );

endmodule

// File: tb/tb_patch_image_buffer.sv
// Randomized bench for patch_image_buffer against a frame-level reference model.
// Compile with ZERO_PAD_EN to match a DUT built with the same macro.
module tb_patch_image_buffer;

  localparam int N = 784;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid, wr_ready, wr_last;
  logic [7:0] wr_data;
  logic       frame_start, frame_ready, frame_consumed, frame_err;
  logic [9:0] addr1, addr2;
  logic [7:0] data1, data2;

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  logic [7:0] mem_m [N];
  bit         known [N];
  bit         m_full, m_err;
  int         m_cnt;
  logic [7:0] e_d1, e_d2;
  bit         k1, k2;

  always #5 clk = ~clk;

  patch_image_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_data        (wr_data),
    .wr_last        (wr_last),
    .frame_start    (frame_start),
    .frame_ready    (frame_ready),
    .frame_consumed (frame_consumed),
    .frame_err      (frame_err),
    .addr1          (addr1),
    .addr2          (addr2),
    .data1          (data1),
    .data2          (data2)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("wr_ready", 16'(wr_ready), 16'(!m_full));
    check("frame_ready", 16'(frame_ready), 16'(m_full));
    check("frame_err", 16'(frame_err), 16'(m_err));
    if (k1) check("data1", 16'(data1), 16'(e_d1));
    if (k2) check("data2", 16'(data2), 16'(e_d2));
  endtask

  // One clock: advance the model from the current inputs, then compare.
  task automatic tick();
    logic [7:0] n1, n2;
    bit         nk1, nk2, acc;
    n1 = e_d1; nk1 = k1;
    n2 = e_d2; nk2 = k2;
    if (int'(addr1) < N) begin n1 = mem_m[addr1]; nk1 = known[addr1]; end
`ifdef ZERO_PAD_EN
    else begin n1 = 8'h00; nk1 = 1'b1; end
`endif
    if (int'(addr2) < N) begin n2 = mem_m[addr2]; nk2 = known[addr2]; end
`ifdef ZERO_PAD_EN
    else begin n2 = 8'h00; nk2 = 1'b1; end
`endif
    acc = wr_valid && !m_full;
    if (acc) begin
      mem_m[m_cnt] = wr_data;
      known[m_cnt] = 1'b1;
    end
    if (frame_start) begin
      m_full = 1'b0; m_cnt = 0; m_err = 1'b0;
    end else if (acc) begin
      if (wr_last != (m_cnt == N - 1)) m_err = 1'b1;
      if (wr_last || m_cnt == N - 1) begin
        m_full = 1'b1; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else if (m_full && frame_consumed) begin
      m_full = 1'b0; m_cnt = 0;
    end
    @(posedge clk); #1;
    e_d1 = n1; k1 = nk1;
    e_d2 = n2; k2 = nk2;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    m_full = 1'b0; m_cnt = 0; m_err = 1'b0;
    e_d1 = 8'h00; e_d2 = 8'h00; k1 = 1'b1; k2 = 1'b1;
    check_outputs();
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input bit last);
    wr_valid = 1'b1; wr_data = d; wr_last = last;
    tick();
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  logic [7:0] old5;

  initial begin
    wr_valid = 0; wr_data = 0; wr_last = 0;
    frame_start = 0; frame_consumed = 0;
    addr1 = 0; addr2 = 0; rst = 0;
    for (int i = 0; i < N; i++) known[i] = 1'b0;

    // 1: reset values
    do_reset();
    check("t1_data1", 16'(data1), 16'h0);
    check("t1_data2", 16'(data2), 16'h0);
    check("t1_wr_ready", 16'(wr_ready), 16'h1);

    // 2: full frame in raster order with idle gaps and random reads
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(3) == 0) tick();
      addr1 = 10'($urandom_range(N - 1));
      addr2 = 10'($urandom_range(N - 1));
      push(8'(i), i == N - 1);
    end
    check("t2_frame_ready", 16'(frame_ready), 16'h1);
    check("t2_wr_ready", 16'(wr_ready), 16'h0);
    check("t2_frame_err", 16'(frame_err), 16'h0);
    addr1 = 10'd0; addr2 = 10'd783;
    tick();
    check("t2_rd0", 16'(data1), 16'h00);
    check("t2_rd783", 16'(data2), 16'h0F);

    // 3: writes blocked while full, then release
    wr_valid = 1'b1; wr_data = 8'h55;
    repeat (10) tick();
    wr_valid = 1'b0;
    tick();
    check("t3_mem0", 16'(data1), 16'h00);
    frame_consumed = 1'b1;
    tick();
    frame_consumed = 1'b0;
    check("t3_wr_ready", 16'(wr_ready), 16'h1);

    // 4: early wr_last, restart, then reset mid-load
    for (int i = 0; i < 100; i++) push(8'($urandom), i == 99);
    check("t4_full", 16'(frame_ready), 16'h1);
    check("t4_err", 16'(frame_err), 16'h1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("t4_err_clr", 16'(frame_err), 16'h0);
    for (int i = 0; i < 400; i++) push(8'($urandom), 1'b0);
    do_reset();
    push(8'hA5, 1'b0);
    push(8'h3C, 1'b0);
    addr1 = 10'd0; addr2 = 10'd1;
    tick();
    check("t4_restart0", 16'(data1), 16'hA5);
    check("t4_restart1", 16'(data2), 16'h3C);

    // 5: read-before-write and same-address dual read
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(i + 8'h20), 1'b0);
    old5 = mem_m[5];
    addr1 = 10'd5;
    push(8'h7F, 1'b0);
    check("t5_rbw_old", 16'(data1), 16'(old5));
    tick();
    check("t5_rbw_new", 16'(data1), 16'h7F);
    for (int i = 6; i < 13; i++) push(8'(i * 3), 1'b0);
    addr1 = 10'd12; addr2 = 10'd12;
    tick();
    check("t5_same_addr1", 16'(data1), 16'(8'(36)));
    check("t5_same_addr2", 16'(data2), 16'(8'(36)));

    // 6: out-of-image read
    addr1 = 10'd3;
    tick();
    addr1 = 10'd800;
    tick();
`ifdef ZERO_PAD_EN
    check("t6_pad", 16'(data1), 16'h00);
`else
    check("t6_hold", 16'(data1), 16'h23);
`endif

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      wr_valid       = ($urandom_range(3) != 0);
      wr_data        = 8'($urandom);
      wr_last        = ($urandom_range(299) == 0);
      frame_start    = ($urandom_range(599) == 0);
      frame_consumed = ($urandom_range(19) == 0);
      addr1          = 10'($urandom);
      addr2          = 10'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
